// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port memory bus between the instruction-fetch requester
// (i_*) and the load/store requester (d_*). Only one transaction is in flight
// at a time. Data requests win arbitration, but once MAX_D_BURST data grants
// have been made back-to-back while a fetch was waiting, the fetch gets the
// next slot. A fetch may be cancelled (pipe flush) at any point. The memory
// command still runs to completion, and only the fetch ack is suppressed.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   i_req/i_addr        fetch request and address, held until i_ack/i_cancel
//   i_cancel            drop the pending or in-flight fetch
//   i_ack/i_rdata       one-cycle fetch completion and instruction word
//   d_req/d_we/d_addr/
//   d_wdata/d_wstrb     data request payload, held until d_ack
//   d_ack/d_rdata       one-cycle data completion and load data
//   m_valid/m_ready     memory command handshake (m_valid held until m_ready)
//   m_we/m_addr/
//   m_wdata/m_wstrb     memory command payload (m_wstrb is 0 for reads)
//   m_rvalid/m_rdata    memory completion pulse and read data
//
// Every output comes straight from a register.
// ----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int MAX_D_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_cancel,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  // memory port
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  localparam int STREAK_W = $clog2(MAX_D_BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

  state_t              r_state;
  owner_t              r_owner;
  logic                r_cancelled;
  logic [STREAK_W-1:0] r_d_streak;

  logic                r_m_valid;
  logic                r_m_we;
  logic [31:0]         r_m_addr;
  logic [31:0]         r_m_wdata;
  logic [3:0]          r_m_wstrb;
  logic                r_i_ack;
  logic [31:0]         r_i_rdata;
  logic                r_d_ack;
  logic [31:0]         r_d_rdata;

  // Arbitration, only acted on in IDLE. The streak cap only bites while a
  // fetch is actually waiting.
  logic w_streak_full;
  logic w_grant_d;
  logic w_grant_i;

  assign w_streak_full = (r_d_streak == STREAK_W'(MAX_D_BURST));
  assign w_grant_d     = d_req && !(i_req && w_streak_full);
  assign w_grant_i     = !w_grant_d && i_req && !i_cancel;

  // The completion cycle: the memory response is seen in ISSUE (same cycle
  // as m_ready) or in WAIT. A response at any other time is ignored.
  logic w_resp_enter;
  logic w_cancel_now;

  assign w_resp_enter = ((r_state == S_ISSUE) && m_ready && m_rvalid) ||
                        ((r_state == S_WAIT) && m_rvalid);
  assign w_cancel_now = ((r_state == S_ISSUE) || (r_state == S_WAIT)) &&
                        (r_owner == OWN_I) && i_cancel;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register reads the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_I;
      r_cancelled <= 1'b0;
      r_d_streak  <= '0;
      r_m_valid   <= 1'b0;
      r_m_we      <= 1'b0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_m_wstrb   <= '0;
      r_i_ack     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_ack     <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      // Acks are single-cycle pulses unless set below on completion.
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_owner   <= OWN_D;
            r_m_valid <= 1'b1;
            r_m_we    <= d_we;
            r_m_addr  <= d_addr;
            r_m_wdata <= d_wdata;
            r_m_wstrb <= d_we ? d_wstrb : 4'b0000;
            r_state   <= S_ISSUE;
            if (!i_req) begin
              r_d_streak <= '0;
            end else if (!w_streak_full) begin
              r_d_streak <= r_d_streak + STREAK_W'(1);
            end
          end else if (w_grant_i) begin
            r_owner    <= OWN_I;
            r_m_valid  <= 1'b1;
            r_m_we     <= 1'b0;
            r_m_addr   <= i_addr;
            r_m_wdata  <= '0;
            r_m_wstrb  <= 4'b0000;
            r_state    <= S_ISSUE;
            r_d_streak <= '0;
          end
        end

        S_ISSUE: begin
          // The command stays on the bus even if the fetch is cancelled.
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= m_rvalid ? S_RESP : S_WAIT;
          end
        end

        S_WAIT: begin
          if (m_rvalid) begin
            r_state <= S_RESP;
          end
        end

        S_RESP: begin
          // No arbitration here: a requester still holding req for the
          // transaction just acked must not be granted a second time.
          r_state     <= S_IDLE;
          r_cancelled <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_cancel_now) begin
        r_cancelled <= 1'b1;
      end

      if (w_resp_enter) begin
        if (r_owner == OWN_D) begin
          r_d_rdata <= m_rdata;
          r_d_ack   <= 1'b1;
        end else begin
          r_i_rdata <= m_rdata;
          // A cancel on the completion cycle itself also suppresses the ack.
          r_i_ack   <= !(r_cancelled || i_cancel);
        end
      end
    end
  end

  assign m_valid = r_m_valid;
  assign m_we    = r_m_we;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign m_wstrb = r_m_wstrb;
  assign i_ack   = r_i_ack;
  assign i_rdata = r_i_rdata;
  assign d_ack   = r_d_ack;
  assign d_rdata = r_d_rdata;

endmodule
